uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning: data bits per frame, legal 5..9.
REQ-002 Parameter PARITY_MODE, default 1, meaning: 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 1, meaning: stop bits per frame, legal 1..2.
REQ-004 Parameter FIFO_DEPTH, default 8, meaning: transmit FIFO entries, power of two, 2..64.
REQ-005 CLK  input  1  system clock; all logic on rising edge.
REQ-006 CLR_N  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 DIV  input  16  clocks per bit period; values below 2 treated as 2.
REQ-008 Enable  input  1  high permits new frames to start.
REQ-009 Data  input  DATA_BITS  word to enqueue.
REQ-010 Valid  input  1  Data is offered this cycle.
REQ-011 Ready  output  1  FIFO can accept; equals not-full, registered.
REQ-012 OUT_ser  output  1  serial line, idle high, registered.
REQ-013 Busy  output  1  high while a frame is on the line.
REQ-014 Count  output  log2(FIFO_DEPTH)+1  words held in FIFO.

Function
REQ-015 A word SHALL be enqueued on every rising edge where Valid and Ready are both high; Valid with Ready low is ignored, not held.
REQ-016 Frame format SHALL be: start bit 0, DATA_BITS data LSB first, optional parity bit, STOP_BITS stop bits of 1.
REQ-017 Even parity SHALL make the total count of ones in data plus parity even; odd parity makes it odd.
REQ-018 Each bit SHALL last exactly DIV clocks, DIV sampled once at the start bit and held for the whole frame.
REQ-019 State machine SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE is 0.
REQ-020 In IDLE with Enable high and Count nonzero, the FIFO head SHALL be popped and loaded into the shift register on one edge, with OUT_ser driven 0 and state set to START on the same edge.
REQ-021 Latency: handshake at edge n into an empty FIFO while IDLE SHALL give OUT_ser low from edge n+1.
REQ-022 At the end of the final stop bit, if Enable is high and Count is nonzero, the next start bit SHALL begin on the next edge with no idle gap; otherwise the block returns to IDLE with OUT_ser high.
REQ-023 Enable low mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-024 Push and pop on the same edge SHALL leave Count unchanged; with the FIFO full, Ready stays low that cycle and rises on the following edge.
REQ-025 Busy SHALL be high in every state except IDLE.
REQ-026 Changes to DIV, PARITY-related inputs or Data during a frame SHALL NOT alter the frame in flight.

Reset
REQ-027 CLR_N low SHALL asynchronously force OUT_ser=1, Busy=0, Count=0, Ready=1, state IDLE, and clear the FIFO pointers and baud counter.
REQ-028 Reset asserted mid-frame SHALL truncate the frame immediately; no partial data is re-sent after release.
REQ-029 The first frame after reset release SHALL NOT start before the edge following the first handshake.

Structure
REQ-030 Package uart_pkg SHALL hold the state encoding, the PARITY_MODE constants (PAR_NONE, PAR_EVEN, PAR_ODD) and a clog2 function.
REQ-031 Sub-module uart_baud_gen SHALL provide a DIV-clock bit-period tick, restartable at frame start; FIFO storage stays inline.

Verification
REQ-032 Defaults, DIV=4, push 0xA5 -> line reads 0,1,0,1,0,0,1,0,1,0(parity),1, each 4 clocks, 44 clocks total, then idle high.
REQ-033 PARITY_MODE=2, DATA_BITS=7, STOP_BITS=2, push 0x03 -> parity bit 1, two stop bits, frame 11*DIV clocks.
REQ-034 FIFO_DEPTH=4, push 5 words back-to-back with Enable low -> Ready low after the 4th, 5th ignored, Count=4; raise Enable -> 4 frames with no idle gap.
REQ-035 DIV=1 -> bit period 2 clocks; change DIV from 4 to 8 mid-frame -> current frame stays at 4, next frame uses 8.
REQ-036 Assert CLR_N low during data bit 3 -> OUT_ser=1 and Busy=0 at once; Count=0; no further frames after release.
REQ-037 Enable dropped during data bit 2 with 2 words queued -> current frame completes, line idles, Count=1 held until Enable returns.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity mode constants and clog2 helper
package uart_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: host-side handshake, configuration and line status bundle
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8,
  parameter int CW        = 4
) ();
  logic [15:0]          DIV;
  logic                 Enable;
  logic [DATA_BITS-1:0] Data;
  logic                 Valid;
  logic                 Ready;
  logic                 OUT_ser;
  logic                 Busy;
  logic [CW-1:0]        Count;
  modport master (output DIV, Enable, Data, Valid, input Ready, OUT_ser, Busy, Count);
  modport slave  (input DIV, Enable, Data, Valid, output Ready, OUT_ser, Busy, Count);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: one-clock tick every div clocks, held at phase zero while restart is high
module uart_baud_gen (
  input  logic        CLK,
  input  logic        CLR_N,
  input  logic        restart,
  input  logic [15:0] div,
  output logic        tick
);
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == div - 16'd1;
    cnt_d = (restart || tick) ? '0 : cnt_q + 16'd1;
  end
  always_ff @(posedge CLK or negedge CLR_N)
    if (!CLR_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with configurable data, parity and stop bits
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = PAR_EVEN,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input logic            CLK,
  input logic            CLR_N,
  uart_tx_param_if.slave bus
);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] sh_q, sh_d, head;
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2:0]           state_q, state_d;
  logic [3:0]           bit_q, bit_d;
  logic [15:0]          div_q, div_d;
  logic ready_q, ready_d, out_q, out_d, par_q, par_d;
  logic push, pop, start_ok, tick;
  uart_baud_gen u_baud (
    .CLK,
    .CLR_N,
    .restart(state_q == S_IDLE),
    .div    (div_q),
    .tick
  );
  assign head     = mem_q[rd_q];
  assign push     = bus.Valid & ready_q;
  assign start_ok = bus.Enable & (count_q != '0);
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    par_d   = par_q;
    div_d   = div_q;
    out_d   = out_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE:  pop = start_ok;
      S_START: if (tick) begin
        state_d = S_DATA;
        out_d   = sh_q[0];
        sh_d    = sh_q >> 1;
        bit_d   = '0;
      end
      S_DATA: if (tick) begin
        if (bit_q == 4'(DATA_BITS - 1)) begin
          state_d = (PARITY_MODE != PAR_NONE) ? S_PARITY : S_STOP;
          out_d   = (PARITY_MODE != PAR_NONE) ? par_q : 1'b1;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 4'd1;
          out_d = sh_q[0];
          sh_d  = sh_q >> 1;
        end
      end
      S_PARITY: if (tick) begin
        state_d = S_STOP;
        out_d   = 1'b1;
      end
      S_STOP: if (tick) begin
        if (bit_q == 4'(STOP_BITS - 1)) begin
          pop     = start_ok;
          state_d = S_IDLE;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // frame start: head, parity and bit period are captured together so the frame is immune to later input changes
    if (pop) begin
      state_d = S_START;
      sh_d    = head;
      par_d   = ^head ^ (PARITY_MODE == PAR_ODD);
      div_d   = (bus.DIV < 16'd2) ? 16'd2 : bus.DIV;
      out_d   = 1'b0;
    end
  end
  always_comb begin
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    ready_d = count_d != CW'(FIFO_DEPTH);
  end
  always_ff @(posedge CLK)
    if (push) mem_q[wr_q] <= bus.Data;
  always_ff @(posedge CLK or negedge CLR_N)
    if (!CLR_N) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      par_q   <= 1'b0;
      div_q   <= 16'd2;
      out_q   <= 1'b1;
      bit_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      div_q   <= div_d;
      out_q   <= out_d;
      bit_q   <= bit_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  assign bus.Ready   = ready_q;
  assign bus.OUT_ser = out_q;
  assign bus.Busy    = state_q != S_IDLE;
  assign bus.Count   = count_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: two parameterisations driven by shared stimulus, each checked per cycle against a waveform model
module tb_uart_tx_param;
  import uart_pkg::*;
  logic CLK = 1'b0;
  logic CLR_N = 1'b0;
  logic [15:0] div = 16'd4;
  logic en = 1'b0;
  logic valid = 1'b0;
  logic [8:0] data = '0;
  logic ser [2];
  logic busy [2];
  logic rdy [2];
  logic [6:0] cnt [2];
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int DB = (g == 0) ? 8 : 7;
    localparam int PM = (g == 0) ? PAR_EVEN : PAR_ODD;
    localparam int SB = (g == 0) ? 1 : 2;
    localparam int FD = (g == 0) ? 8 : 4;
    localparam int CW = clog2(FD) + 1;
    uart_tx_param_if #(.DATA_BITS(DB), .CW(CW)) bus ();
    assign bus.DIV    = div;
    assign bus.Enable = en;
    assign bus.Valid  = valid;
    assign bus.Data   = data[DB-1:0];
    uart_tx_param #(.DATA_BITS(DB), .PARITY_MODE(PM), .STOP_BITS(SB), .FIFO_DEPTH(FD)) dut (
      .CLK  (CLK),
      .CLR_N(CLR_N),
      .bus  (bus)
    );
    assign ser[g]  = bus.OUT_ser;
    assign busy[g] = bus.Busy;
    assign rdy[g]  = bus.Ready;
    assign cnt[g]  = 7'(bus.Count);

    // model: queued words plus the remaining per-clock line levels of the frame in flight
    logic [DB-1:0] mq [$];
    logic mw [$];
    logic fb [$];
    logic m_ser = 1'b1, m_busy = 1'b0, m_rdy = 1'b1, pu;
    logic [DB-1:0] w;
    int d, ones;
    always @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
        mq.delete();
        mw.delete();
        m_ser = 1'b1;
        m_busy = 1'b0;
        m_rdy = 1'b1;
      end else begin
        pu = valid && m_rdy;
        if (mw.size() > 0) m_ser = mw.pop_front();
        else if (en && mq.size() > 0) begin
          w = mq.pop_front();
          d = (div < 16'd2) ? 2 : int'(div);
          fb = {1'b0};
          for (int i = 0; i < DB; i++) fb.push_back(w[i]);
          ones = $countones(w);
          if (PM == PAR_EVEN) fb.push_back(ones % 2 == 1);
          else if (PM == PAR_ODD) fb.push_back(ones % 2 == 0);
          repeat (SB) fb.push_back(1'b1);
          foreach (fb[i]) repeat (d) mw.push_back(fb[i]);
          m_ser = mw.pop_front();
          m_busy = 1'b1;
        end else begin
          m_ser = 1'b1;
          m_busy = 1'b0;
        end
        if (pu) mq.push_back(data[DB-1:0]);
        m_rdy = mq.size() != FD;
      end
    end
    always @(negedge CLK) begin
      chk($sformatf("u%0d_ser", g), 32'(ser[g]), 32'(m_ser));
      chk($sformatf("u%0d_busy", g), 32'(busy[g]), 32'(m_busy));
      chk($sformatf("u%0d_ready", g), 32'(rdy[g]), 32'(m_rdy));
      chk($sformatf("u%0d_count", g), 32'(cnt[g]), 32'(mq.size()));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    tick();
    while ((busy[0] || busy[1]) && c < 3000) begin
      c++;
      tick();
    end
    chk({nm, "_idle_timeout"}, 32'(c < 3000), 32'd1);
  endtask

  task automatic low_run(input int idx, output int r);
    r = 0;
    while (ser[idx] == 1'b0 && r < 200) begin
      r++;
      tick();
    end
  endtask

  task automatic frame_lit(input string nm, input int idx, input logic [8:0] wd, input logic [10:0] e);
    valid = 1'b1;
    data = wd;
    tick();
    valid = 1'b0;
    chk({nm, "_pre_start"}, 32'(ser[idx]), 32'd1);
    tick();
    chk({nm, "_start_latency"}, 32'(ser[idx]), 32'd0);
    repeat (3) tick();
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("%s_bit%0d", nm, k), 32'(ser[idx]), 32'(e[k]));
      if (k < 10) repeat (4) tick();
    end
    chk({nm, "_busy_last_clock"}, 32'(busy[idx]), 32'd1);
    tick();
    chk({nm, "_busy_after_44"}, 32'(busy[idx]), 32'd0);
    chk({nm, "_idle_high"}, 32'(ser[idx]), 32'd1);
  endtask

  initial begin
    int r, r0, r1;
    bit d0, d1;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ser%0d", i), 32'(ser[i]), 32'd1);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("rst_count%0d", i), 32'(cnt[i]), 32'd0);
    end
    CLR_N = 1'b1;
    en = 1'b1;
    repeat (3) tick();
    chk("no_frame_before_push", 32'(busy[0]), 32'd0);
    frame_lit("a5_even", 0, 9'h0A5, 11'b10101001010);
    frame_lit("03_odd7_2stop", 1, 9'h003, 11'b11100000110);
    div = 16'd1;
    valid = 1'b1;
    data = 9'h001;
    tick();
    valid = 1'b0;
    tick();
    low_run(0, r);
    chk("div1_start_len", 32'(r), 32'd2);
    wait_idle("div1");
    div = 16'd4;
    valid = 1'b1;
    data = 9'h001;
    repeat (2) tick();
    valid = 1'b0;
    div = 16'd8;
    low_run(0, r);
    chk("div4_start_len", 32'(r), 32'd4);
    repeat (40) tick();
    chk("div8_back_to_back", 32'(ser[0]), 32'd0);
    low_run(0, r);
    chk("div8_start_len", 32'(r), 32'd8);
    wait_idle("divchg");
    div = 16'd4;
    en = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = 9'($urandom);
      tick();
      if (i == 2) chk("full_ready_before", 32'(rdy[1]), 32'd1);
      if (i == 3) chk("full_ready_low", 32'(rdy[1]), 32'd0);
    end
    valid = 1'b0;
    chk("full_count4", 32'(cnt[1]), 32'd4);
    chk("deep_count5", 32'(cnt[0]), 32'd5);
    en = 1'b1;
    tick();
    r0 = 0;
    r1 = 0;
    d0 = 0;
    d1 = 0;
    for (int c = 0; c < 1000 && !(d0 && d1); c++) begin
      if (!d0) begin
        if (busy[0]) r0++;
        else d0 = 1;
      end
      if (!d1) begin
        if (busy[1]) r1++;
        else d1 = 1;
      end
      tick();
    end
    chk("burst5_no_gap", 32'(r0), 32'd220);
    chk("burst4_no_gap", 32'(r1), 32'd176);
    valid = 1'b1;
    data = 9'h05A;
    tick();
    data = 9'h133;
    tick();
    valid = 1'b0;
    repeat (13) tick();
    en = 1'b0;
    wait_idle("en_drop");
    chk("en_drop_count0", 32'(cnt[0]), 32'd1);
    chk("en_drop_count1", 32'(cnt[1]), 32'd1);
    repeat (20) tick();
    chk("en_drop_held", 32'(cnt[0]), 32'd1);
    chk("en_drop_idle", 32'(busy[0]), 32'd0);
    en = 1'b1;
    tick();
    chk("en_resume", 32'(busy[0]), 32'd1);
    wait_idle("en_resume");
    for (int c = 0; c < 2500; c++) begin
      valid = $urandom_range(0, 2) == 0;
      data = 9'($urandom);
      en = $urandom_range(0, 7) != 0;
      div = 16'($urandom_range(0, 5));
      tick();
    end
    valid = 1'b0;
    en = 1'b1;
    div = 16'd4;
    wait_idle("random_drain");
    valid = 1'b1;
    data = 9'h0C3;
    repeat (2) tick();
    valid = 1'b0;
    repeat (17) tick();
    #2 CLR_N = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrst_ser%0d", i), 32'(ser[i]), 32'd1);
      chk($sformatf("midrst_busy%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("midrst_count%0d", i), 32'(cnt[i]), 32'd0);
      chk($sformatf("midrst_ready%0d", i), 32'(rdy[i]), 32'd1);
    end
    @(posedge CLK);
    #3 CLR_N = 1'b1;
    repeat (100) tick();
    chk("post_rst_quiet0", 32'(busy[0]), 32'd0);
    chk("post_rst_quiet1", 32'(busy[1]), 32'd0);
    chk("post_rst_line", 32'(ser[0]), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1);
  end
endmodule
